// File: rtl/collision_scanner.sv
// ----------------------------------------------------------------------------
// collision_scanner
//
// Purpose:
//    Sequencer between the object table RAM and the collision detector. On a
//    start request it reads a reference object from the table and drives it
//    to the detector's "a" side. It then walks every other object 0..last_idx
//    onto the "b" side, one at a time. For each object it collects the
//    detector's verdict into a hit mask and a hit count, which the game CPU
//    reads once done pulses.
//
// Per-candidate sequence (4 cycles):
//    RD_OBJ (read strobe) -> LD_OBJ (capture table data into det_b)
//    -> SETTLE (detector registers its corners) -> SAMPLE (use det_collision)
//
// Latency:
//    If start is sampled at cycle 0, done pulses at cycle 3 + 4*K, where K is
//    the number of objects scanned.
//
// Configuration macro:
//    SCAN_EARLY_EXIT_EN - when defined, the first hit ends the scan. The mask
//                         then holds at most one set bit. When undefined,
//                         every candidate is scanned.
//
// Ports:
//    clk              clock
//    rst_n            asynchronous active-low reset
//    i_start          1-cycle scan request, honoured only in IDLE
//    i_ref_idx        table index of the reference object (sampled on start)
//    i_last_idx       highest table index to scan (sampled on start)
//    o_busy           high from the cycle after start through DONE
//    o_done           1-cycle pulse when the results are valid
//    o_hit_mask       bit i set = object i collided with the reference
//    o_hit_count      number of set bits in o_hit_mask
//    o_tbl_rd_en      table read strobe
//    o_tbl_rd_idx     table read index
//    i_tbl_rd_data    {x,y,w,h}, 8 bits each, valid 1 cycle after the strobe
//    o_det_a_*        reference box to the detector
//    o_det_b_*        candidate box to the detector
//    i_det_collision  detector verdict, 1 cycle behind its box inputs
// ----------------------------------------------------------------------------
module collision_scanner #(
   parameter int MAX_OBJ = 16,
   parameter int IDX_W   = $clog2(MAX_OBJ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [IDX_W-1:0]   i_ref_idx,
   input  logic [IDX_W-1:0]   i_last_idx,
   output logic               o_busy,
   output logic               o_done,
   output logic [MAX_OBJ-1:0] o_hit_mask,
   output logic [IDX_W:0]     o_hit_count,
   output logic               o_tbl_rd_en,
   output logic [IDX_W-1:0]   o_tbl_rd_idx,
   input  logic [31:0]        i_tbl_rd_data,
   output logic [7:0]         o_det_a_x,
   output logic [7:0]         o_det_a_y,
   output logic [7:0]         o_det_a_w,
   output logic [7:0]         o_det_a_h,
   output logic [7:0]         o_det_b_x,
   output logic [7:0]         o_det_b_y,
   output logic [7:0]         o_det_b_w,
   output logic [7:0]         o_det_b_h,
   input  logic               i_det_collision
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_REF = 3'd1,
      S_LD_REF = 3'd2,
      S_RD_OBJ = 3'd3,
      S_LD_OBJ = 3'd4,
      S_SETTLE = 3'd5,
      S_SAMPLE = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_ref_idx;
   logic [IDX_W-1:0]   r_last_idx;
   logic [IDX_W-1:0]   r_cursor;
   logic               r_busy;
   logic               r_done;
   logic [MAX_OBJ-1:0] r_hit_mask;
   logic [IDX_W:0]     r_hit_count;
   logic               r_rd_en;
   logic [IDX_W-1:0]   r_rd_idx;
   logic [7:0]         r_a_x, r_a_y, r_a_w, r_a_h;
   logic [7:0]         r_b_x, r_b_y, r_b_w, r_b_h;

   // Candidate arithmetic is one bit wider than an index so that stepping
   // past MAX_OBJ-1 cannot wrap back to a small index.
   logic [IDX_W:0]     w_first;
   logic               w_first_ok;
   logic [IDX_W:0]     w_step;
   logic [IDX_W:0]     w_next;
   logic               w_next_ok;
   logic               w_early_exit;

`ifdef SCAN_EARLY_EXIT_EN
   assign w_early_exit = i_det_collision;
`else
   assign w_early_exit = 1'b0;
`endif

   // First and next candidate index; the reference index is always skipped.
   always_comb begin
      w_first    = {{IDX_W{1'b0}}, (r_ref_idx == {IDX_W{1'b0}})};
      w_first_ok = (w_first <= {1'b0, r_last_idx});
      w_step     = {1'b0, r_cursor} + {{IDX_W{1'b0}}, 1'b1};
      if (w_step == {1'b0, r_ref_idx}) begin
         w_next = w_step + {{IDX_W{1'b0}}, 1'b1};
      end else begin
         w_next = w_step;
      end
      w_next_ok = (w_next <= {1'b0, r_last_idx});
   end

   // Scan FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ref_idx   <= {IDX_W{1'b0}};
         r_last_idx  <= {IDX_W{1'b0}};
         r_cursor    <= {IDX_W{1'b0}};
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_hit_mask  <= {MAX_OBJ{1'b0}};
         r_hit_count <= {(IDX_W+1){1'b0}};
         r_rd_en     <= 1'b0;
         r_rd_idx    <= {IDX_W{1'b0}};
         r_a_x       <= 8'd0;
         r_a_y       <= 8'd0;
         r_a_w       <= 8'd0;
         r_a_h       <= 8'd0;
         r_b_x       <= 8'd0;
         r_b_y       <= 8'd0;
         r_b_w       <= 8'd0;
         r_b_h       <= 8'd0;
      end else begin
         // Strobes are single-cycle unless a state below re-asserts them.
         r_done  <= 1'b0;
         r_rd_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_ref_idx   <= i_ref_idx;
                  r_last_idx  <= i_last_idx;
                  r_cursor    <= {IDX_W{1'b0}};
                  r_hit_mask  <= {MAX_OBJ{1'b0}};
                  r_hit_count <= {(IDX_W+1){1'b0}};
                  r_busy      <= 1'b1;
                  r_rd_en     <= 1'b1;
                  r_rd_idx    <= i_ref_idx;
                  r_state     <= S_RD_REF;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RD_REF: begin
               r_state <= S_LD_REF;
            end
            S_LD_REF: begin
               r_a_x <= i_tbl_rd_data[31:24];
               r_a_y <= i_tbl_rd_data[23:16];
               r_a_w <= i_tbl_rd_data[15:8];
               r_a_h <= i_tbl_rd_data[7:0];
               if (w_first_ok) begin
                  r_cursor <= w_first[IDX_W-1:0];
                  r_rd_en  <= 1'b1;
                  r_rd_idx <= w_first[IDX_W-1:0];
                  r_state  <= S_RD_OBJ;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_RD_OBJ: begin
               r_state <= S_LD_OBJ;
            end
            S_LD_OBJ: begin
               r_b_x   <= i_tbl_rd_data[31:24];
               r_b_y   <= i_tbl_rd_data[23:16];
               r_b_w   <= i_tbl_rd_data[15:8];
               r_b_h   <= i_tbl_rd_data[7:0];
               r_state <= S_SETTLE;
            end
            S_SETTLE: begin
               // Detector latches the new candidate corners on this edge.
               r_state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               if (i_det_collision) begin
                  r_hit_mask[r_cursor] <= 1'b1;
                  r_hit_count          <= r_hit_count + {{IDX_W{1'b0}}, 1'b1};
               end else begin
                  r_hit_count <= r_hit_count;
               end
               if (w_next_ok && !w_early_exit) begin
                  r_cursor <= w_next[IDX_W-1:0];
                  r_rd_en  <= 1'b1;
                  r_rd_idx <= w_next[IDX_W-1:0];
                  r_state  <= S_RD_OBJ;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_hit_mask   = r_hit_mask;
   assign o_hit_count  = r_hit_count;
   assign o_tbl_rd_en  = r_rd_en;
   assign o_tbl_rd_idx = r_rd_idx;
   assign o_det_a_x    = r_a_x;
   assign o_det_a_y    = r_a_y;
   assign o_det_a_w    = r_a_w;
   assign o_det_a_h    = r_a_h;
   assign o_det_b_x    = r_b_x;
   assign o_det_b_y    = r_b_y;
   assign o_det_b_w    = r_b_w;
   assign o_det_b_h    = r_b_h;

endmodule

// File: tb/tb_collision_scanner.sv
// ----------------------------------------------------------------------------
// tb_collision_scanner
//
// Table-driven bench for collision_scanner. It models the object table RAM
// (registered read, data one cycle after the strobe) and the collision
// detector (corners registered, inclusive-edge overlap). Each vector gives
// the table contents, the scan request, and the expected mask, count, done
// cycle and read order. Hand-written sequences cover a start issued
// mid-scan and a reset issued mid-scan.
// ----------------------------------------------------------------------------
module tb_collision_scanner;

`ifdef SCAN_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  ref_idx = 4'd0;
   logic [3:0]  last_idx = 4'd0;
   logic        busy, done, tbl_rd_en, det_collision;
   logic [15:0] hit_mask;
   logic [4:0]  hit_count;
   logic [3:0]  tbl_rd_idx;
   logic [31:0] tbl_rd_data = 32'h0;
   logic [7:0]  det_a_x, det_a_y, det_a_w, det_a_h;
   logic [7:0]  det_b_x, det_b_y, det_b_w, det_b_h;

   collision_scanner #(.MAX_OBJ(16), .IDX_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_ref_idx(ref_idx),
      .i_last_idx(last_idx), .o_busy(busy), .o_done(done),
      .o_hit_mask(hit_mask), .o_hit_count(hit_count),
      .o_tbl_rd_en(tbl_rd_en), .o_tbl_rd_idx(tbl_rd_idx),
      .i_tbl_rd_data(tbl_rd_data),
      .o_det_a_x(det_a_x), .o_det_a_y(det_a_y), .o_det_a_w(det_a_w), .o_det_a_h(det_a_h),
      .o_det_b_x(det_b_x), .o_det_b_y(det_b_y), .o_det_b_w(det_b_w), .o_det_b_h(det_b_h),
      .i_det_collision(det_collision)
   );

   always #5 clk = ~clk;

   // Object table RAM model.
   logic [31:0] mem [16];
   always @(posedge clk) begin
      if (tbl_rd_en) tbl_rd_data <= mem[tbl_rd_idx];
   end

   // Detector model: corners registered, inclusive overlap.
   logic [7:0] ax1 = 8'd0, ax2 = 8'd0, ay1 = 8'd0, ay2 = 8'd0;
   logic [7:0] bx1 = 8'd0, bx2 = 8'd0, by1 = 8'd0, by2 = 8'd0;
   always @(posedge clk) begin
      ax1 <= det_a_x; ax2 <= det_a_x + det_a_w;
      ay1 <= det_a_y; ay2 <= det_a_y + det_a_h;
      bx1 <= det_b_x; bx2 <= det_b_x + det_b_w;
      by1 <= det_b_y; by2 <= det_b_y + det_b_h;
   end
   assign det_collision = (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);

   // Log of every table read index.
   logic [3:0] rd_log [256];
   int         rd_total = 0;
   always @(negedge clk) begin
      if (tbl_rd_en) begin
         rd_log[rd_total % 256] = tbl_rd_idx;
         rd_total = rd_total + 1;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cur_vec  = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", cur_vec, name, act, exp);
   endtask

   function automatic logic [31:0] box(input int x, input int y, input int w, input int h);
      return {x[7:0], y[7:0], w[7:0], h[7:0]};
   endfunction

   typedef struct {
      logic [3:0]       ref_i;
      logic [3:0]       last_i;
      logic [3:0][31:0] objs;
      logic [15:0]      mask;
      logic [4:0]       cnt;
      int               cyc;
      int               nrd;
      logic [3:0][3:0]  rd;
   } vec_t;

   vec_t vecs [7];

   // Runs one scan of vecs[vi]. extra_cyc: cycle at which a second start is
   // pulsed (-1 = none). rst_cyc: cycle at which rst_n is pulled low (-1 = none).
   task automatic run(input int vi, input int extra_cyc, input int rst_cyc);
      int          base;
      int          dc;
      bit          got;
      logic [15:0] m;
      logic [4:0]  c;
      cur_vec = vi;
      for (int j = 0; j < 16; j++) mem[j] = (j < 4) ? vecs[vi].objs[j] : 32'h0;
      base = rd_total;
      @(negedge clk);
      start    = 1'b1;
      ref_idx  = vecs[vi].ref_i;
      last_idx = vecs[vi].last_i;
      got = 1'b0; dc = 0; m = 16'h0; c = 5'd0;
      for (int k = 1; k < 80 && !got; k++) begin
         @(negedge clk);
         start = (k == extra_cyc);
         if (k == extra_cyc) begin
            ref_idx  = 4'd1;
            last_idx = 4'd0;
         end
         if (k == 1) chk("busy_after_start", {31'd0, busy}, 32'd1);
         if (k == rst_cyc) begin
            chk("busy_before_rst", {31'd0, busy}, 32'd1);
            rst_n = 1'b0;
            #1;
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_mask", {16'd0, hit_mask}, 32'd0);
            chk("rst_count", {27'd0, hit_count}, 32'd0);
            chk("rst_rd_en", {31'd0, tbl_rd_en}, 32'd0);
            chk("rst_rd_idx", {28'd0, tbl_rd_idx}, 32'd0);
            chk("rst_det_a", {det_a_x, det_a_y, det_a_w, det_a_h}, 32'd0);
            chk("rst_det_b", {det_b_x, det_b_y, det_b_w, det_b_h}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (done) begin
            got = 1'b1; dc = k; m = hit_mask; c = hit_count;
         end
      end
      chk("done_seen", {31'd0, got}, 32'd1);
      if (got) begin
         chk("done_cycle", dc, vecs[vi].cyc);
         chk("hit_mask", {16'd0, m}, {16'd0, vecs[vi].mask});
         chk("hit_count", {27'd0, c}, {27'd0, vecs[vi].cnt});
         chk("num_reads", rd_total - base, vecs[vi].nrd);
         for (int j = 0; j < vecs[vi].nrd && j < 4; j++)
            chk("read_order", {28'd0, rd_log[(base + j) % 256]}, {28'd0, vecs[vi].rd[j]});
         chk("det_a_hold", {det_a_x, det_a_y, det_a_w, det_a_h}, vecs[vi].objs[vecs[vi].ref_i[1:0]]);
         if (vecs[vi].nrd > 1)
            chk("det_b_hold", {det_b_x, det_b_y, det_b_w, det_b_h},
                vecs[vi].objs[vecs[vi].rd[vecs[vi].nrd-1][1:0]]);
         @(negedge clk);
         chk("done_one_cycle", {31'd0, done}, 32'd0);
         chk("busy_after_done", {31'd0, busy}, 32'd0);
         repeat (3) @(negedge clk);
         chk("mask_held", {16'd0, hit_mask}, {16'd0, vecs[vi].mask});
      end
   endtask

   initial begin
      // 0: basic scan, one hit
      vecs[0].ref_i = 4'd0; vecs[0].last_i = 4'd2;
      vecs[0].objs = {32'h0, box(100,100,4,4), box(12,12,2,2), box(10,10,5,5)};
      vecs[0].mask = 16'h0002; vecs[0].cnt = 5'd1;
      vecs[0].cyc = EE ? 7 : 11; vecs[0].nrd = EE ? 2 : 3;
      vecs[0].rd = {4'd0, 4'd2, 4'd1, 4'd0};
      // 1: edge touch counts as a hit
      vecs[1].ref_i = 4'd0; vecs[1].last_i = 4'd1;
      vecs[1].objs = {32'h0, 32'h0, box(15,10,3,3), box(10,10,5,5)};
      vecs[1].mask = 16'h0002; vecs[1].cnt = 5'd1; vecs[1].cyc = 7; vecs[1].nrd = 2;
      vecs[1].rd = {4'd0, 4'd0, 4'd1, 4'd0};
      // 2: no candidates
      vecs[2].ref_i = 4'd0; vecs[2].last_i = 4'd0;
      vecs[2].objs = vecs[0].objs;
      vecs[2].mask = 16'h0000; vecs[2].cnt = 5'd0; vecs[2].cyc = 3; vecs[2].nrd = 1;
      vecs[2].rd = {4'd0, 4'd0, 4'd0, 4'd0};
      // 3: reference is the last index
      vecs[3].ref_i = 4'd2; vecs[3].last_i = 4'd2;
      vecs[3].objs = {32'h0, box(50,50,10,10), box(45,45,6,6), box(55,55,2,2)};
      vecs[3].mask = EE ? 16'h0001 : 16'h0003; vecs[3].cnt = EE ? 5'd1 : 5'd2;
      vecs[3].cyc = EE ? 7 : 11; vecs[3].nrd = EE ? 2 : 3;
      vecs[3].rd = {4'd0, 4'd1, 4'd0, 4'd2};
      // 4: two hits (early-exit behaviour differs)
      vecs[4].ref_i = 4'd0; vecs[4].last_i = 4'd2;
      vecs[4].objs = {32'h0, box(14,14,3,3), box(12,12,2,2), box(10,10,5,5)};
      vecs[4].mask = EE ? 16'h0002 : 16'h0006; vecs[4].cnt = EE ? 5'd1 : 5'd2;
      vecs[4].cyc = EE ? 7 : 11; vecs[4].nrd = EE ? 2 : 3;
      vecs[4].rd = {4'd0, 4'd2, 4'd1, 4'd0};
      // 5: ref_idx > last_idx, all of 0..last scanned
      vecs[5].ref_i = 4'd3; vecs[5].last_i = 4'd1;
      vecs[5].objs = {box(22,22,8,8), 32'h0, box(200,200,10,10), box(20,20,4,4)};
      vecs[5].mask = 16'h0001; vecs[5].cnt = 5'd1;
      vecs[5].cyc = EE ? 7 : 11; vecs[5].nrd = EE ? 2 : 3;
      vecs[5].rd = {4'd0, 4'd1, 4'd0, 4'd3};
      // 6: reference in the middle, all misses
      vecs[6].ref_i = 4'd1; vecs[6].last_i = 4'd3;
      vecs[6].objs = {box(100,100,5,5), box(0,6,1,1), box(0,0,5,5), box(6,0,2,2)};
      vecs[6].mask = 16'h0000; vecs[6].cnt = 5'd0; vecs[6].cyc = 15; vecs[6].nrd = 4;
      vecs[6].rd = {4'd3, 4'd2, 4'd0, 4'd1};

      // Reset state
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_mask", {16'd0, hit_mask}, 32'd0);
      chk("reset_count", {27'd0, hit_count}, 32'd0);
      chk("reset_rd_en", {31'd0, tbl_rd_en}, 32'd0);
      chk("reset_det", {det_a_x, det_b_x, det_a_h, det_b_h}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 7; v++) run(v, -1, -1);

      // Start pulsed mid-scan is ignored
      run(0, 5, -1);
      // Reset mid-scan, then a normal scan recovers
      run(0, -1, 6);
      @(negedge clk);
      cur_vec = 100;
      chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
      run(1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
